ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single-port matrix RAM between N_REQ requesters (operand loader, C writeback, host load/dump).
//  Grants one access per cycle with round-robin arbitration, plus an optional lock for uninterrupted bursts.
//  Registers the RAM address, write-enable and write-data, and routes read data back to the requester that issued it.
//  Sits between the matrix-multiply control unit(s) and the RAM; it is the only driver of ram_addr/ram_we/ram_w_data.
// PARAMETERS
//  data_w     32                 RAM word width
//  ram_d      512                RAM depth in words
//  ram_add_w  $clog2(ram_d)      RAM address width
//  N_REQ      3                  number of requesters (2..8)
//  RD_LAT     0                  cycles from ram_addr driven to ram_r_data valid (0..3)
// PORTS
//  clk         in   1                  clock; all logic on posedge
//  rst         in   1                  synchronous reset, active-high
//  req_valid   in   N_REQ              request pending; held until accepted
//  req_we      in   N_REQ              1 = write, 0 = read
//  req_lock    in   N_REQ              keep ownership after this access
//  req_addr    in   N_REQ*ram_add_w    packed addresses; slot i = [i*ram_add_w +: ram_add_w]
//  req_wdata   in   N_REQ*data_w       packed write data; slot i = [i*data_w +: data_w]
//  req_ready   out  N_REQ              one-hot grant; access accepted when req_valid[i] & req_ready[i]
//  rsp_valid   out  N_REQ              one-hot read response strobe
//  rsp_data    out  data_w             read data; valid when any rsp_valid bit is set
//  owner       out  $clog2(N_REQ)      index of the last granted requester
//  locked      out  1                  arbiter is in LOCKED state
//  ram_we      out  1                  RAM write enable (registered)
//  ram_addr    out  ram_add_w          RAM address (registered)
//  ram_w_data  out  data_w             RAM write data (registered)
//  ram_r_data  in   data_w             RAM read data
// BEHAVIOUR
//  Reset values:
//   - state = IDLE; rr pointer = 0; owner = 0; locked = 0.
//   - ram_we, ram_addr, ram_w_data = 0.
//   - rsp_valid = 0; the response delay pipe is cleared.
//   - req_ready = 0 while rst is high.
//  Grant logic (req_ready):
//   - Combinational from req_valid, state and pointer; at most one bit set; never set for a requester whose req_valid is 0.
//   - IDLE: grant the first valid requester at or after the pointer, wrapping N_REQ-1 -> 0.
//   - On acceptance of requester g, the pointer moves to (g+1) mod N_REQ.
//  Lock (LOCKED state):
//   - An accepted access with req_lock[g] = 1 moves IDLE -> LOCKED with owner = g.
//   - In LOCKED, only the owner can be granted; all other requests wait.
//   - The pointer does not move while LOCKED.
//   - An accepted owner access with req_lock = 0 returns the arbiter to IDLE.
//   - An owner idle cycle (req_valid = 0) does not release the lock.
//  Access timing, for an access accepted at cycle t:
//   - ram_addr and ram_we = req_we[g] are driven at t+1.
//   - Writes: ram_w_data = req_wdata slot g at t+1. A write produces no response.
//   - Cycles with no grant: ram_we = 0; ram_addr and ram_w_data hold their previous values.
//  Read response:
//   - rsp_valid[g] pulses for exactly one cycle at t+1+RD_LAT.
//   - rsp_data = ram_r_data (combinational passthrough).
//   - The response pipe is a shift register of requester tags, RD_LAT+1 deep.
//  Ordering and throughput:
//   - Back-to-back accesses run at one per cycle with responses in issue order.
//   - Read-after-write to the same address in consecutive grants returns the new data; this relies on the RAM being write-first.
//  Simultaneous events:
//   - A new grant and a response delivery can occur in the same cycle.
//   - A lock release and a grant to another requester cannot: the release cycle only serves the owner.
//  Reset mid-operation:
//   - In-flight responses are discarded; no rsp_valid is asserted after rst is released until a new read is accepted.
//  Addresses are used unchanged. Requesters must keep addresses < ram_d; there is no range check.
// TESTING
//  1. RD_LAT=0, RAM[5]=32'hDEADBEEF; req 0 reads addr 5 -> req_ready[0]=1 at t, ram_addr=5 at t+1, rsp_valid[0]=1 with rsp_data=32'hDEADBEEF at t+1 for one cycle.
//  2. All 3 requesters read continuously -> grants 0,1,2,0,1,2, one per cycle; no two req_ready bits set in any cycle.
//  3. Req 1 writes 32'h12345678 to addr 511, then req 2 reads 511 -> ram_we=1 for one cycle; rsp_data=32'h12345678 on rsp_valid[2]; rsp_valid[1] never set.
//  4. Req 2 makes 4 accesses with lock=1,1,1,0 while reqs 0 and 1 stay valid -> only req 2 granted for 4 cycles, locked=1 for cycles 2-4, then req 0 granted.
//  5. RD_LAT=2, reqs 0 and 1 read addrs 10 and 11 back-to-back -> rsp_valid[0] at t+3, rsp_valid[1] at t+4, with the correct data each.
//  6. RD_LAT=2, rst asserted for 1 cycle with 2 reads in flight -> all outputs at reset values, no rsp_valid after release, pointer back at 0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter that shares one single-port RAM between N_REQ requesters,
// with an ownership lock for bursts and a tagged read-response delay pipe.
module ram_port_arbiter #(
    parameter int data_w    = 32,
    parameter int ram_d     = 512,
    parameter int ram_add_w = $clog2(ram_d),
    parameter int N_REQ     = 3,
    parameter int RD_LAT    = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_we,
    input  logic [N_REQ-1:0]            req_lock,
    input  logic [N_REQ*ram_add_w-1:0]  req_addr,
    input  logic [N_REQ*data_w-1:0]     req_wdata,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [data_w-1:0]           rsp_data,
    output logic [$clog2(N_REQ)-1:0]    owner,
    output logic                        locked,
    output logic                        ram_we,
    output logic [ram_add_w-1:0]        ram_addr,
    output logic [data_w-1:0]           ram_w_data,
    input  logic [data_w-1:0]           ram_r_data
);

    localparam int OW = $clog2(N_REQ);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                          state_q, state_d;
    logic [OW-1:0]                   ptr_q, ptr_d;
    logic [OW-1:0]                   owner_q, owner_d;
    logic                            ram_we_q, ram_we_d;
    logic [ram_add_w-1:0]            ram_addr_q, ram_addr_d;
    logic [data_w-1:0]               ram_w_data_q, ram_w_data_d;
    logic [RD_LAT:0][N_REQ-1:0]      pipe_q, pipe_d;

    logic [N_REQ-1:0]                grant;
    logic [OW-1:0]                   grant_idx;
    logic [OW-1:0]                   cand;
    logic                            found;
    logic                            accept;

    assign accept = |grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_w_data_q <= '0;
            pipe_q       <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_w_data_q <= ram_w_data_d;
            pipe_q       <= pipe_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_w_data_d = ram_w_data_q;
        pipe_d       = '0;
        for (int i = 1; i <= RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        if (accept) begin
            owner_d    = grant_idx;
            ram_we_d   = req_we[grant_idx];
            ram_addr_d = req_addr[int'(grant_idx)*ram_add_w +: ram_add_w];
            if (req_we[grant_idx]) begin
                ram_w_data_d = req_wdata[int'(grant_idx)*data_w +: data_w];
            end else begin
                pipe_d[0] = grant;
            end
            // The pointer only advances on grants made outside a lock.
            if (state_q == IDLE) begin
                ptr_d = (int'(grant_idx) == N_REQ-1) ? '0 : grant_idx + 1'b1;
                if (req_lock[grant_idx]) begin
                    state_d = LOCKED;
                end
            end else if (!req_lock[grant_idx]) begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        if (!rst) begin
            if (state_q == LOCKED) begin
                if (req_valid[owner_q]) begin
                    grant[owner_q] = 1'b1;
                    grant_idx      = owner_q;
                end
            end else begin
                for (int k = 0; k < N_REQ; k++) begin
                    cand = OW'((int'(ptr_q) + k) % N_REQ);
                    if (!found && req_valid[cand]) begin
                        found       = 1'b1;
                        grant[cand] = 1'b1;
                        grant_idx   = cand;
                    end
                end
            end
        end
        req_ready  = grant;
        rsp_valid  = pipe_q[RD_LAT];
        rsp_data   = ram_r_data;
        owner      = owner_q;
        locked     = (state_q == LOCKED);
        ram_we     = ram_we_q;
        ram_addr   = ram_addr_q;
        ram_w_data = ram_w_data_q;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Drives two arbiters (RD_LAT=0 and RD_LAT=2) with the same directed vectors;
// a monitor pops expected read responses from per-instance queues.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid, req_we, req_lock;
    logic [26:0] req_addr;
    logic [95:0] req_wdata;

    logic [2:0]  ready0, rsp_valid0, ready2, rsp_valid2;
    logic [31:0] rsp_data0, rsp_data2;
    logic [1:0]  owner0, owner2;
    logic        locked0, locked2, ram_we0, ram_we2;
    logic [8:0]  ram_addr0, ram_addr2;
    logic [31:0] ram_w_data0, ram_w_data2, ram_r_data0, ram_r_data2;

    logic [31:0] mem0 [512];
    logic [31:0] mem2 [512];
    logic [31:0] rd2_a, rd2_b;

    typedef struct {
        int          tag;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];
    exp_t e0, e2;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    ram_port_arbiter #(.RD_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready0), .rsp_valid(rsp_valid0),
        .rsp_data(rsp_data0), .owner(owner0), .locked(locked0), .ram_we(ram_we0),
        .ram_addr(ram_addr0), .ram_w_data(ram_w_data0), .ram_r_data(ram_r_data0)
    );

    ram_port_arbiter #(.RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready2), .rsp_valid(rsp_valid2),
        .rsp_data(rsp_data2), .owner(owner2), .locked(locked2), .ram_we(ram_we2),
        .ram_addr(ram_addr2), .ram_w_data(ram_w_data2), .ram_r_data(ram_r_data2)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-first RAM models; contents are preloaded while reset is high.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 512; i++) begin
                mem0[i] <= 32'h0;
                mem2[i] <= 32'h0;
            end
            mem0[5]  <= 32'hDEADBEEF;
            mem2[5]  <= 32'hDEADBEEF;
            mem0[10] <= 32'hA5A50010;
            mem2[10] <= 32'hA5A50010;
            mem0[11] <= 32'h5A5A0011;
            mem2[11] <= 32'h5A5A0011;
        end else begin
            if (ram_we0) mem0[ram_addr0] <= ram_w_data0;
            if (ram_we2) mem2[ram_addr2] <= ram_w_data2;
        end
    end

    assign ram_r_data0 = mem0[ram_addr0];

    always @(posedge clk) begin
        rd2_a <= ram_we2 ? ram_w_data2 : mem2[ram_addr2];
        rd2_b <= rd2_a;
    end

    assign ram_r_data2 = rd2_b;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] v, input logic [2:0] we, input logic [2:0] lk,
                                 input logic [26:0] a, input logic [95:0] wd);
        req_valid = v;
        req_we    = we;
        req_lock  = lk;
        req_addr  = a;
        req_wdata = wd;
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic expectRead(input int tag, input logic [31:0] data, input bit lat0_only);
        exp_t e;
        e.tag  = tag;
        e.data = data;
        e.cyc  = cyc + 1;
        q0.push_back(e);
        if (!lat0_only) begin
            e.cyc = cyc + 3;
            q2.push_back(e);
        end
    endtask

    task automatic checkReset(input string pfx);
        checkOutput({pfx, "_ready0"}, 32'(ready0), 32'h0);
        checkOutput({pfx, "_ready2"}, 32'(ready2), 32'h0);
        checkOutput({pfx, "_rspv0"}, 32'(rsp_valid0), 32'h0);
        checkOutput({pfx, "_rspv2"}, 32'(rsp_valid2), 32'h0);
        checkOutput({pfx, "_owner2"}, 32'(owner2), 32'h0);
        checkOutput({pfx, "_locked2"}, 32'(locked2), 32'h0);
        checkOutput({pfx, "_we2"}, 32'(ram_we2), 32'h0);
        checkOutput({pfx, "_addr0"}, 32'(ram_addr0), 32'h0);
        checkOutput({pfx, "_addr2"}, 32'(ram_addr2), 32'h0);
        checkOutput({pfx, "_wdata2"}, ram_w_data2, 32'h0);
    endtask

    // Monitor: every response strobe must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid0 != 3'b000) begin
                if (q0.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL rsp0_unexpected actual=%b expected=none", rsp_valid0);
                end else begin
                    e0 = q0.pop_front();
                    checkOutput("rsp0_tag", 32'(rsp_valid0), 32'(1) << e0.tag);
                    checkOutput("rsp0_data", rsp_data0, e0.data);
                    checkOutput("rsp0_cycle", 32'(cyc), 32'(e0.cyc));
                end
            end
            if (rsp_valid2 != 3'b000) begin
                if (q2.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL rsp2_unexpected actual=%b expected=none", rsp_valid2);
                end else begin
                    e2 = q2.pop_front();
                    checkOutput("rsp2_tag", 32'(rsp_valid2), 32'(1) << e2.tag);
                    checkOutput("rsp2_data", rsp_data2, e2.data);
                    checkOutput("rsp2_cycle", 32'(cyc), 32'(e2.cyc));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        applyStimulus(3'b111, 3'b000, 3'b000, '0, '0);
        step();
        step();
        checkReset("rst");
        rst = 1'b0;
        applyStimulus(3'b000, 3'b000, 3'b000, '0, '0);

        // Continuous reads from all three: grants rotate 0,1,2,...
        step();
        applyStimulus(3'b111, 3'b000, 3'b000, {9'd5, 9'd11, 9'd10}, '0);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("rr_grant0_%0d", i), 32'(ready0), 32'(1) << (i % 3));
            checkOutput($sformatf("rr_grant2_%0d", i), 32'(ready2), 32'(1) << (i % 3));
            case (i % 3)
                0:       expectRead(0, 32'hA5A50010, 1'b0);
                1:       expectRead(1, 32'h5A5A0011, 1'b0);
                default: expectRead(2, 32'hDEADBEEF, 1'b0);
            endcase
            step();
        end
        applyStimulus(3'b000, 3'b000, 3'b000, '0, '0);

        // Single read of address 5.
        step();
        applyStimulus(3'b001, 3'b000, 3'b000, {9'd0, 9'd0, 9'd5}, '0);
        checkOutput("rd5_grant", 32'(ready0), 32'h1);
        expectRead(0, 32'hDEADBEEF, 1'b0);
        step();
        applyStimulus(3'b000, 3'b000, 3'b000, '0, '0);
        checkOutput("rd5_addr0", 32'(ram_addr0), 32'd5);
        checkOutput("rd5_addr2", 32'(ram_addr2), 32'd5);
        checkOutput("rd5_we0", 32'(ram_we0), 32'h0);

        // Write 511 from req 1, then read it back from req 2.
        step();
        applyStimulus(3'b010, 3'b010, 3'b000, {9'd0, 9'd511, 9'd0}, {32'h0, 32'h12345678, 32'h0});
        checkOutput("wr_grant", 32'(ready0), 32'h2);
        step();
        applyStimulus(3'b100, 3'b000, 3'b000, {9'd511, 9'd0, 9'd0}, '0);
        checkOutput("raw_grant", 32'(ready0), 32'h4);
        checkOutput("wr_we0", 32'(ram_we0), 32'h1);
        checkOutput("wr_we2", 32'(ram_we2), 32'h1);
        checkOutput("wr_addr0", 32'(ram_addr0), 32'd511);
        checkOutput("wr_wdata0", ram_w_data0, 32'h12345678);
        expectRead(2, 32'h12345678, 1'b0);
        step();
        applyStimulus(3'b000, 3'b000, 3'b000, '0, '0);
        checkOutput("wr_we_pulse", 32'(ram_we0), 32'h0);

        // Move the pointer to 2 before the lock burst.
        step();
        applyStimulus(3'b010, 3'b000, 3'b000, {9'd0, 9'd11, 9'd0}, '0);
        checkOutput("pre_lock_grant", 32'(ready0), 32'h2);
        expectRead(1, 32'h5A5A0011, 1'b0);
        step();
        applyStimulus(3'b000, 3'b000, 3'b000, '0, '0);

        // Lock burst from req 2 while reqs 0 and 1 keep requesting.
        step();
        applyStimulus(3'b111, 3'b000, 3'b100, {9'd10, 9'd11, 9'd10}, '0);
        checkOutput("lk1_grant", 32'(ready0), 32'h4);
        checkOutput("lk1_locked", 32'(locked0), 32'h0);
        expectRead(2, 32'hA5A50010, 1'b0);
        step();
        applyStimulus(3'b111, 3'b000, 3'b100, {9'd10, 9'd11, 9'd10}, '0);
        checkOutput("lk2_grant", 32'(ready0), 32'h4);
        checkOutput("lk2_locked", 32'(locked0), 32'h1);
        checkOutput("lk2_owner", 32'(owner0), 32'd2);
        expectRead(2, 32'hA5A50010, 1'b0);
        step();
        applyStimulus(3'b011, 3'b000, 3'b000, {9'd10, 9'd11, 9'd10}, '0);
        checkOutput("lk_idle_grant", 32'(ready0), 32'h0);
        checkOutput("lk_idle_locked", 32'(locked2), 32'h1);
        step();
        applyStimulus(3'b111, 3'b000, 3'b100, {9'd10, 9'd11, 9'd10}, '0);
        checkOutput("lk3_grant", 32'(ready2), 32'h4);
        checkOutput("lk3_locked", 32'(locked0), 32'h1);
        expectRead(2, 32'hA5A50010, 1'b0);
        step();
        applyStimulus(3'b111, 3'b000, 3'b000, {9'd10, 9'd11, 9'd10}, '0);
        checkOutput("lk4_grant", 32'(ready0), 32'h4);
        checkOutput("lk4_locked", 32'(locked0), 32'h1);
        expectRead(2, 32'hA5A50010, 1'b0);
        step();
        applyStimulus(3'b011, 3'b000, 3'b000, {9'd10, 9'd11, 9'd10}, '0);
        checkOutput("unlk_grant", 32'(ready0), 32'h1);
        checkOutput("unlk_locked", 32'(locked0), 32'h0);
        expectRead(0, 32'hA5A50010, 1'b0);
        step();
        applyStimulus(3'b000, 3'b000, 3'b000, '0, '0);

        // Back-to-back reads from reqs 0 and 1.
        step();
        applyStimulus(3'b001, 3'b000, 3'b000, {9'd0, 9'd11, 9'd10}, '0);
        checkOutput("b2b_grant0", 32'(ready2), 32'h1);
        expectRead(0, 32'hA5A50010, 1'b0);
        step();
        applyStimulus(3'b010, 3'b000, 3'b000, {9'd0, 9'd11, 9'd10}, '0);
        checkOutput("b2b_grant1", 32'(ready2), 32'h2);
        expectRead(1, 32'h5A5A0011, 1'b0);
        step();
        applyStimulus(3'b000, 3'b000, 3'b000, '0, '0);
        repeat (4) step();

        // Reset with two reads in flight in the RD_LAT=2 instance.
        step();
        applyStimulus(3'b001, 3'b000, 3'b000, {9'd0, 9'd10, 9'd5}, '0);
        checkOutput("inflt_grant0", 32'(ready2), 32'h1);
        expectRead(0, 32'hDEADBEEF, 1'b1);
        step();
        applyStimulus(3'b010, 3'b000, 3'b000, {9'd0, 9'd10, 9'd5}, '0);
        checkOutput("inflt_grant1", 32'(ready2), 32'h2);
        expectRead(1, 32'hA5A50010, 1'b1);
        step();
        applyStimulus(3'b000, 3'b000, 3'b000, '0, '0);
        rst = 1'b1;
        q2.delete();
        step();
        applyStimulus(3'b111, 3'b000, 3'b000, '0, '0);
        checkReset("midrst");
        rst = 1'b0;
        applyStimulus(3'b000, 3'b000, 3'b000, '0, '0);
        repeat (4) step();
        applyStimulus(3'b111, 3'b000, 3'b000, {9'd5, 9'd11, 9'd10}, '0);
        checkOutput("post_rst_ptr0", 32'(ready0), 32'h1);
        checkOutput("post_rst_ptr2", 32'(ready2), 32'h1);
        expectRead(0, 32'hA5A50010, 1'b0);
        step();
        applyStimulus(3'b000, 3'b000, 3'b000, '0, '0);
        repeat (6) step();

        checkOutput("q0_drained", 32'(q0.size()), 32'h0);
        checkOutput("q2_drained", 32'(q2.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
